// File: rtl/stream_pkg.sv
// Shared types for the stream_reduce slice.
//   state_e      : control FSM states of the reducer
//   DefaultWidth : default data/sum/count width
//   beat_t       : one upstream beat (valid, done, data) at the default width
package stream_pkg;

    localparam int unsigned DefaultWidth = 32;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StAccum,
        StEmit
    } state_e;

    typedef struct packed {
        logic                    valid;
        logic                    done;
        logic [DefaultWidth-1:0] data;
    } beat_t;

endpackage

// File: rtl/stream_reduce_acc.sv
// Accumulator datapath for stream_reduce: wrapping signed sum and unsigned beat count,
// plus signed min/max when STREAM_REDUCE_MINMAX_EN is defined.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   clear_i             : zero all accumulators on the next edge (wins over acc_en_i)
//   acc_en_i            : fold data_i into the accumulators on the next edge
//   data_i              : signed input value
//   sum_o, count_o      : running sum and beat count
//   min_o, max_o        : running signed min/max (STREAM_REDUCE_MINMAX_EN only)
module stream_reduce_acc
    import stream_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             acc_en_i,
    input  logic [WIDTH-1:0] data_i,
`ifdef STREAM_REDUCE_MINMAX_EN
    output logic [WIDTH-1:0] min_o,
    output logic [WIDTH-1:0] max_o,
`endif
    output logic [WIDTH-1:0] sum_o,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] count_q, count_d;

    // Plain modular adds: both sum and count wrap by design.
    always_comb begin
        sum_d   = sum_q;
        count_d = count_q;
        if (clear_i) begin
            sum_d   = '0;
            count_d = '0;
        end else if (acc_en_i) begin
            sum_d   = sum_q + data_i;
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_q   <= '0;
            count_q <= '0;
        end else begin
            sum_q   <= sum_d;
            count_q <= count_d;
        end
    end

    assign sum_o   = sum_q;
    assign count_o = count_q;

`ifdef STREAM_REDUCE_MINMAX_EN
    logic             seen_q, seen_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] max_q, max_d;

    // seen_q marks that min/max hold a real sample; until then the first beat seeds both,
    // and an empty stream leaves them at the cleared value of 0.
    always_comb begin
        seen_d = seen_q;
        min_d  = min_q;
        max_d  = max_q;
        if (clear_i) begin
            seen_d = 1'b0;
            min_d  = '0;
            max_d  = '0;
        end else if (acc_en_i) begin
            seen_d = 1'b1;
            if (!seen_q || ($signed(data_i) < $signed(min_q))) begin
                min_d = data_i;
            end
            if (!seen_q || ($signed(data_i) > $signed(max_q))) begin
                max_d = data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seen_q <= 1'b0;
            min_q  <= '0;
            max_q  <= '0;
        end else begin
            seen_q <= seen_d;
            min_q  <= min_d;
            max_q  <= max_d;
        end
    end

    assign min_o = min_q;
    assign max_o = max_q;
`endif

endmodule

// File: rtl/stream_reduce.sv
// Stream reducer: launches an upstream range-style generator, drains its
// valid/done stream and returns one result beat (sum and count of up_0).
// Optional macro STREAM_REDUCE_MINMAX_EN adds signed min (_2) and max (_3) outputs.
// Ports:
//   _clock, _reset       : clock, asynchronous active-high reset
//   _start               : request; honoured only when idle
//   _ready               : downstream accepts the result beat
//   _valid, _done        : result beat valid (both asserted together)
//   _0, _1               : signed sum, unsigned beat count
//   _2, _3               : signed min, max (STREAM_REDUCE_MINMAX_EN only)
//   up_start, up_ready   : launch pulse and ready toward upstream
//   up_valid, up_done    : upstream beat valid / end of stream
//   up_0                 : upstream data
module stream_reduce
    import stream_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             _clock,
    input  logic             _reset,
    input  logic             _start,
    input  logic             _ready,
    output logic             _valid,
    output logic             _done,
    output logic [WIDTH-1:0] _0,
    output logic [WIDTH-1:0] _1,
`ifdef STREAM_REDUCE_MINMAX_EN
    output logic [WIDTH-1:0] _2,
    output logic [WIDTH-1:0] _3,
`endif
    output logic             up_start,
    output logic             up_ready,
    input  logic             up_valid,
    input  logic             up_done,
    input  logic [WIDTH-1:0] up_0
);

    state_e state_q, state_d;
    logic   up_start_q, up_start_d;
    logic   up_ready_q, up_ready_d;
    logic   valid_q, valid_d;
    logic   acc_clear;
    logic   acc_en;

    always_comb begin
        state_d   = state_q;
        acc_clear = 1'b0;
        acc_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (_start) begin
                    acc_clear = 1'b1;
                    state_d   = StLaunch;
                end
            end
            StLaunch: state_d = StAccum;
            StAccum: begin
                // A beat arriving with up_done is still folded in before leaving.
                acc_en = up_valid;
                if (up_done) begin
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (_ready) begin
                    state_d = StIdle;
                end
            end
        endcase

        // Outputs are registered decodes of the state being entered.
        up_start_d = (state_d == StLaunch);
        up_ready_d = (state_d == StAccum);
        valid_d    = (state_d == StEmit);
    end

    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            state_q    <= StIdle;
            up_start_q <= 1'b0;
            up_ready_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            up_start_q <= up_start_d;
            up_ready_q <= up_ready_d;
            valid_q    <= valid_d;
        end
    end

    stream_reduce_acc #(
        .WIDTH(WIDTH)
    ) u_acc (
        .clk_i   (_clock),
        .rst_i   (_reset),
        .clear_i (acc_clear),
        .acc_en_i(acc_en),
        .data_i  (up_0),
`ifdef STREAM_REDUCE_MINMAX_EN
        .min_o   (_2),
        .max_o   (_3),
`endif
        .sum_o   (_0),
        .count_o (_1)
    );

    assign up_start = up_start_q;
    assign up_ready = up_ready_q;
    assign _valid   = valid_q;
    assign _done    = valid_q;

endmodule

// File: tb/tb_stream_reduce.sv
// Scoreboard bench for stream_reduce: a 32-bit instance for most vectors and an 8-bit
// instance for narrow wrap-around. Both share one bench-driven upstream beat bus.
module tb_stream_reduce;
    import stream_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start32, ready32, start8, ready8;
    logic        up_valid, up_done;
    logic [31:0] up_0;

    logic        valid32, done32, up_start32, up_ready32;
    logic [31:0] s32, c32;
    logic        valid8, done8, up_start8, up_ready8;
    logic [7:0]  s8, c8;
`ifdef STREAM_REDUCE_MINMAX_EN
    logic [31:0] min32, max32;
    logic [7:0]  min8, max8;
`endif

    stream_reduce #(.WIDTH(32)) dut32 (
        ._clock  (clk),
        ._reset  (rst),
        ._start  (start32),
        ._ready  (ready32),
        ._valid  (valid32),
        ._done   (done32),
        ._0      (s32),
        ._1      (c32),
`ifdef STREAM_REDUCE_MINMAX_EN
        ._2      (min32),
        ._3      (max32),
`endif
        .up_start(up_start32),
        .up_ready(up_ready32),
        .up_valid(up_valid),
        .up_done (up_done),
        .up_0    (up_0)
    );

    stream_reduce #(.WIDTH(8)) dut8 (
        ._clock  (clk),
        ._reset  (rst),
        ._start  (start8),
        ._ready  (ready8),
        ._valid  (valid8),
        ._done   (done8),
        ._0      (s8),
        ._1      (c8),
`ifdef STREAM_REDUCE_MINMAX_EN
        ._2      (min8),
        ._3      (max8),
`endif
        .up_start(up_start8),
        .up_ready(up_ready8),
        .up_valid(up_valid),
        .up_done (up_done),
        .up_0    (up_0[7:0])
    );

    typedef struct {
        logic [31:0] sum;
        logic [31:0] cnt;
        logic [31:0] mn;
        logic [31:0] mx;
    } exp_t;

    exp_t  q32[$];
    exp_t  q8[$];
    beat_t bq[$];
    int    total = 0;
    int    bad = 0;
    int    starts_seen = 0;
    int    launches = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b", name, act, exp);
        end
    endtask

    function automatic void add(input logic v, input logic d, input logic [31:0] x);
        beat_t b;
        b.valid = v;
        b.done  = d;
        b.data  = x;
        bq.push_back(b);
    endfunction

    // hrange(a,b,s): a, a+s, ... < b with done on the last beat; empty range is a bare done.
    function automatic void add_range(input int a, input int b, input int s);
        if (a >= b) begin
            add(1'b0, 1'b1, 32'd0);
        end else begin
            for (int x = a; x < b; x += s) begin
                add(1'b1, (x + s >= b), 32'(x));
            end
        end
    endfunction

    function automatic void exp32(input logic [31:0] s, input logic [31:0] c,
                                  input logic [31:0] mn, input logic [31:0] mx);
        exp_t e;
        e.sum = s; e.cnt = c; e.mn = mn; e.mx = mx;
        q32.push_back(e);
    endfunction

    function automatic void exp8(input logic [31:0] s, input logic [31:0] c,
                                 input logic [31:0] mn, input logic [31:0] mx);
        exp_t e;
        e.sum = s; e.cnt = c; e.mn = mn; e.mx = mx;
        q8.push_back(e);
    endfunction

    // Monitor: pops the scoreboard on every accepted result beat.
    exp_t m32, m8;
    always @(negedge clk) begin
        if (up_start32 || up_start8) starts_seen++;
        if (!rst && valid32 && ready32) begin
            if (q32.size() == 0) begin
                total++; bad++;
                $display("FAIL sb32_unexpected: got beat sum %0h want none", s32);
            end else begin
                m32 = q32.pop_front();
                chk("sb32_sum", s32, m32.sum);
                chk("sb32_cnt", c32, m32.cnt);
                chk1("sb32_done", done32, 1'b1);
`ifdef STREAM_REDUCE_MINMAX_EN
                chk("sb32_min", min32, m32.mn);
                chk("sb32_max", max32, m32.mx);
`endif
            end
        end
        if (!rst && valid8 && ready8) begin
            if (q8.size() == 0) begin
                total++; bad++;
                $display("FAIL sb8_unexpected: got beat sum %0h want none", s8);
            end else begin
                m8 = q8.pop_front();
                chk("sb8_sum", {24'd0, s8}, {24'd0, m8.sum[7:0]});
                chk("sb8_cnt", {24'd0, c8}, {24'd0, m8.cnt[7:0]});
                chk1("sb8_done", done8, 1'b1);
`ifdef STREAM_REDUCE_MINMAX_EN
                chk("sb8_min", {24'd0, min8}, {24'd0, m8.mn[7:0]});
                chk("sb8_max", {24'd0, max8}, {24'd0, m8.mx[7:0]});
`endif
            end
        end
    end

    task automatic launch(input bit sel);
        launches++;
        if (sel) start8 = 1'b1; else start32 = 1'b1;
        @(posedge clk); #1;
        start8  = 1'b0;
        start32 = 1'b0;
        chk1("launch_up_start", sel ? up_start8 : up_start32, 1'b1);
        chk1("launch_up_ready", sel ? up_ready8 : up_ready32, 1'b0);
        @(posedge clk); #1;
        chk1("accum_up_ready", sel ? up_ready8 : up_ready32, 1'b1);
        chk1("accum_up_start", sel ? up_start8 : up_start32, 1'b0);
    endtask

    task automatic drain(input bit sel);
        beat_t b;
        while (bq.size() > 0) begin
            b = bq.pop_front();
            up_valid = b.valid;
            up_done  = b.done;
            up_0     = b.data;
            @(posedge clk); #1;
        end
        up_valid = 1'b0;
        up_done  = 1'b0;
        chk1("latency_valid", sel ? valid8 : valid32, 1'b1);
    endtask

    task automatic wait_idle(input bit sel);
        int n = 0;
        while ((sel ? valid8 : valid32) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk1("back_to_idle", sel ? valid8 : valid32, 1'b0);
    endtask

    task automatic run32();
        launch(1'b0);
        drain(1'b0);
        wait_idle(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start32 = 1'b0; start8 = 1'b0;
        ready32 = 1'b1; ready8 = 1'b1;
        up_valid = 1'b0; up_done = 1'b0; up_0 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_valid", valid32, 1'b0);
        chk1("rst_done", done32, 1'b0);
        chk("rst_sum", s32, 32'd0);
        chk("rst_cnt", c32, 32'd0);
        chk1("rst_up_start", up_start32, 1'b0);
        chk1("rst_up_ready", up_ready32, 1'b0);
        chk1("rst_valid8", valid8, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // hrange(1,11,3)
        add_range(1, 11, 3); exp32(32'd22, 32'd4, 32'd1, 32'd10); run32();
        // hrange(0,10,2) back-to-back
        for (int i = 0; i < 3; i++) begin
            add_range(0, 10, 2); exp32(32'd20, 32'd5, 32'd0, 32'd8); run32();
        end
        // empty hrange(5,5,1)
        add_range(5, 5, 1); exp32(32'd0, 32'd0, 32'd0, 32'd0); run32();
        // negatives with a bubble: -5, gap, 3, -7
        add(1'b1, 1'b0, 32'hFFFF_FFFB); add(1'b0, 1'b0, 32'h1234);
        add(1'b1, 1'b0, 32'd3); add(1'b1, 1'b1, 32'hFFFF_FFF9);
        exp32(32'hFFFF_FFF7, 32'd3, 32'hFFFF_FFF9, 32'd3); run32();
        // 32-bit wrap
        add(1'b1, 1'b0, 32'h7FFF_FFFF); add(1'b1, 1'b1, 32'd1);
        exp32(32'h8000_0000, 32'd2, 32'd1, 32'h7FFF_FFFF); run32();

        // WIDTH=8: 100+100 wraps to -56 (0xC8)
        add(1'b1, 1'b0, 32'd100); add(1'b1, 1'b1, 32'd100);
        exp8(32'hC8, 32'd2, 32'd100, 32'd100);
        launch(1'b1); drain(1'b1); wait_idle(1'b1);
        chk1("idle32_during_w8", valid32, 1'b0);

        // Backpressure in EMIT with ignored _start pulses
        ready32 = 1'b0;
        add_range(1, 11, 3); exp32(32'd22, 32'd4, 32'd1, 32'd10);
        launch(1'b0); drain(1'b0);
        for (int i = 0; i < 3; i++) begin
            chk1("bp_valid", valid32, 1'b1);
            chk1("bp_done", done32, 1'b1);
            chk("bp_sum", s32, 32'd22);
            chk("bp_cnt", c32, 32'd4);
            chk1("bp_up_ready", up_ready32, 1'b0);
            start32 = 1'b1;
            @(posedge clk); #1;
        end
        start32 = 1'b0;
        ready32 = 1'b1;
        wait_idle(1'b0);
        chk("bp_queue_drained", 32'(q32.size()), 32'd0);

        // Reset mid-ACCUM after two beats
        launch(1'b0);
        up_valid = 1'b1; up_0 = 32'd3;
        @(posedge clk); #1;
        up_0 = 32'd4;
        @(posedge clk); #1;
        up_valid = 1'b0;
        chk("pre_rst_cnt", c32, 32'd2);
        rst = 1'b1;
        #1;
        chk1("mid_rst_valid", valid32, 1'b0);
        chk1("mid_rst_done", done32, 1'b0);
        chk1("mid_rst_up_ready", up_ready32, 1'b0);
        chk("mid_rst_sum", s32, 32'd0);
        chk("mid_rst_cnt", c32, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        add_range(0, 10, 2); exp32(32'd20, 32'd5, 32'd0, 32'd8); run32();

        repeat (3) @(posedge clk);
        #1;
        chk("sb32_empty", 32'(q32.size()), 32'd0);
        chk("sb8_empty", 32'(q8.size()), 32'd0);
        chk("launch_count", 32'(starts_seen), 32'(launches));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
